axi_mem_responder: RTL
======================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 64-bit memory words; power of two, at least 2.
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0: byte address mapped to word 0; 8-byte aligned.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port axi_req_i  input  $bits(ariane_axi::req_t)  AXI4 request from the initiator.
REQ-006 SHALL have port axi_resp_o  output  $bits(ariane_axi::resp_t)  AXI4 response to the initiator.

Function
REQ-007 SHALL hold a DEPTH x 64-bit storage array with no reset or initial value.
REQ-008 SHALL address storage by word index = ((beat_addr - BASE_ADDR) >> 3), taking the low log2(DEPTH) bits.
REQ-009 SHALL run the write FSM with states W_IDLE, W_DATA and W_RESP; reset state W_IDLE.
REQ-010 SHALL drive aw_ready = 1 only in W_IDLE; on an AW handshake it SHALL capture id, addr, len, size, burst and atop, clear the beat counter, and go to W_DATA.
REQ-011 SHALL drive w_ready = 1 only in W_DATA; each W handshake SHALL write the bytes whose strb bit is set, and only those bytes.
REQ-012 SHALL end the write burst on the beat where beat counter == len, then go to W_RESP; w.last SHALL be ignored for burst length.
REQ-013 SHALL hold b_valid = 1 in W_RESP with the captured id, user = 0, and the resp given by REQ-017; the b_ready handshake SHALL return the FSM to W_IDLE.
REQ-014 SHALL run the read FSM with states R_IDLE and R_DATA; reset state R_IDLE; ar_ready = 1 only in R_IDLE.
REQ-015 SHALL assert r_valid the cycle after the AR handshake, and the cycle after each non-last R handshake.
REQ-016 SHALL register r.data when a beat is loaded and hold r.data, r.resp, r.last and r.id stable while r_valid && !r_ready.
REQ-017 SHALL advance the address per beat as follows:
  - burst FIXED: address unchanged;
  - burst INCR with size == 3: address + 8;
  - size != 3, burst WRAP or reserved, or (write only) atop != 0: resp SLVERR, no storage update, read data 0, all len+1 beats still transferred.
REQ-018 SHALL set r.last = 1 on beat len and return to R_IDLE after that beat's handshake; the read ready-to-AR gap is 1 cycle minimum.
REQ-019 SHALL resolve a write and a read-beat load to the same word in the same cycle by returning the pre-write data.
REQ-020 SHALL run the read and write FSMs independently and concurrently; exactly one outstanding transaction per direction.
REQ-021 SHALL report a write resp as the worst resp of any beat, with DECERR > SLVERR > OKAY.

Reset
REQ-022 SHALL, while rst_i = 1, drive aw_ready, w_ready, ar_ready, b_valid and r_valid to 0, and drive r/b payload to 0.
REQ-023 SHALL, on the first cycle after rst_i falls, drive aw_ready = ar_ready = 1.
REQ-024 SHALL, if reset is asserted mid-burst, abandon the burst without a response; storage contents SHALL be unchanged by reset.

Configuration
REQ-025 SHALL, when AXI_MEM_RESPONDER_DECERR_EN is defined, flag a beat whose address lies outside [BASE_ADDR, BASE_ADDR + 8*DEPTH) as DECERR, with no write and read data 0.
REQ-026 SHALL, when AXI_MEM_RESPONDER_DECERR_EN is undefined, wrap out-of-range addresses by the index truncation of REQ-008 and respond OKAY.

Verification
REQ-027 SHALL cover a single write then read: AW addr 0x40, len 0, size 3, INCR, W data 0x1122334455667788, strb 0xFF, id 5 -> B OKAY id 5; AR same address -> r.data 0x1122334455667788, r.last 1, r_valid the cycle after the AR handshake.
REQ-028 SHALL cover a partial strobe: word 0x40 preloaded with all ones, write data 0, strb 0x0F -> read returns 0xFFFFFFFF00000000.
REQ-029 SHALL cover an INCR burst with back-pressure: read len 3 from 0x0 with r_ready toggling every cycle -> 4 beats with data stable while stalled, r.last only on beat 4, ar_ready low until the last handshake.
REQ-030 SHALL cover error handling: write with atop 0x20, or size 2, len 1 -> both W beats accepted, storage unchanged, B SLVERR.
REQ-031 SHALL cover out-of-range access: with DEPTH 256 and the macro defined, read 0x800 -> DECERR, data 0; without the macro -> OKAY and the data of word 0.
REQ-032 SHALL cover reset mid-burst: assert rst_i during beat 2 of a len 3 write -> all valid/ready 0 during reset; after release aw_ready = 1 and no B is issued.

Source files
------------

// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//
// AXI4 slave backed by a DEPTH x 64-bit word memory. Independent write
// (AW/W/B) and read (AR/R) engines, each handling one transaction at a time.
// Beats with an unsupported size/burst (or a write atop) complete as SLVERR
// and do not touch storage. Read data for such beats is zero.
//
// Build option:
//   AXI_MEM_RESPONDER_DECERR_EN  when defined, beats outside
//                                [BASE_ADDR, BASE_ADDR + 8*DEPTH) complete as
//                                DECERR. Otherwise such addresses alias into the
//                                array through index truncation and return OKAY.
//
// Parameters:
//   DEPTH      number of 64-bit words (power of two, >= 2)
//   BASE_ADDR  byte address of word 0 (8-byte aligned)
//
// Ports:
//   clk_i       clock, all state changes on the rising edge
//   rst_i       synchronous active-high reset
//   axi_req_i   AXI4 request bundle (AW, W, B ready, AR, R ready)
//   axi_resp_o  AXI4 response bundle (AW/W/AR ready, B, R)
// -----------------------------------------------------------------------------

package ariane_axi;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [UserWidth-1:0] user_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Encoding is ordered by severity, so a numeric max picks the worst resp.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_mem_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ariane_axi::req_t  axi_req_i,
  output ariane_axi::resp_t axi_resp_o
);
  import ariane_axi::*;

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------
  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [1:0] burst);
    return (burst == BURST_INCR) ? addr + 64'd8 : addr;
  endfunction

  // Only full-width FIXED/INCR beats are supported.
  function automatic logic proto_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd3) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
  endfunction

  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef AXI_MEM_RESPONDER_DECERR_EN
  function automatic logic out_of_range(input logic [63:0] addr);
    return (addr < BASE_ADDR) || (((addr - BASE_ADDR) >> 3) >= 64'(DEPTH));
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [63:0]      mem_q [DEPTH];
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;

  // NOTE: the array has no reset branch; contents survive reset and a reset
  // loop over DEPTH words would prevent mapping onto RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (axi_req_i.w.strb[b]) begin
          mem_q[mem_widx][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  w_state_e    w_state_q, w_state_d;
  id_t         w_id_q,    w_id_d;
  logic [63:0] w_addr_q,  w_addr_d;
  logic [7:0]  w_len_q,   w_len_d;
  logic [2:0]  w_size_q,  w_size_d;
  logic [1:0]  w_burst_q, w_burst_d;
  logic [5:0]  w_atop_q,  w_atop_d;
  logic [7:0]  w_cnt_q,   w_cnt_d;
  logic [1:0]  w_bresp_q, w_bresp_d;

  logic        aw_ready, w_ready, b_valid;
  logic [1:0]  w_beat_resp;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_atop_d  = w_atop_q;
    w_cnt_d   = w_cnt_q;
    w_bresp_d = w_bresp_q;

    aw_ready  = !rst_i && (w_state_q == W_IDLE);
    w_ready   = !rst_i && (w_state_q == W_DATA);
    b_valid   = !rst_i && (w_state_q == W_RESP);

    w_beat_resp = RESP_OKAY;
    if (proto_err(w_size_q, w_burst_q) || (w_atop_q != '0)) begin
      w_beat_resp = RESP_SLVERR;
    end
`ifdef AXI_MEM_RESPONDER_DECERR_EN
    if (out_of_range(w_addr_q)) begin
      w_beat_resp = RESP_DECERR;
    end
`endif

    mem_we   = 1'b0;
    mem_widx = word_idx(w_addr_q);

    unique case (w_state_q)
      W_IDLE: begin
        if (axi_req_i.aw_valid && aw_ready) begin
          w_id_d    = axi_req_i.aw.id;
          w_addr_d  = axi_req_i.aw.addr;
          w_len_d   = axi_req_i.aw.len;
          w_size_d  = axi_req_i.aw.size;
          w_burst_d = axi_req_i.aw.burst;
          w_atop_d  = axi_req_i.aw.atop;
          w_cnt_d   = '0;
          w_bresp_d = RESP_OKAY;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_req_i.w_valid && w_ready) begin
          mem_we    = (w_beat_resp == RESP_OKAY);
          w_bresp_d = worse(w_bresp_q, w_beat_resp);
          w_addr_d  = next_addr(w_addr_q, w_burst_q);
          w_cnt_d   = w_cnt_q + 8'd1;
          // Burst length comes from AW len; w.last is not trusted.
          if (w_cnt_q == w_len_q) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (axi_req_i.b_ready && b_valid) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q, r_state_d;
  id_t         r_id_q,    r_id_d;
  logic [63:0] r_addr_q,  r_addr_d;   // address of the next beat to load
  logic [7:0]  r_len_q,   r_len_d;
  logic [2:0]  r_size_q,  r_size_d;
  logic [1:0]  r_burst_q, r_burst_d;
  logic [7:0]  r_cnt_q,   r_cnt_d;
  logic [63:0] r_data_q,  r_data_d;
  logic [1:0]  r_resp_q,  r_resp_d;
  logic        r_last_q,  r_last_d;

  logic        ar_ready, r_valid, r_load;
  logic [63:0] ld_addr, ld_data;
  logic [2:0]  ld_size;
  logic [1:0]  ld_burst, ld_resp;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_data_d  = r_data_q;
    r_resp_d  = r_resp_q;
    r_last_d  = r_last_q;

    ar_ready  = !rst_i && (r_state_q == R_IDLE);
    r_valid   = !rst_i && (r_state_q == R_DATA);
    r_load    = 1'b0;

    // Beat 0 is loaded straight from the AR channel, later beats from the
    // captured burst. The array read is taken before any same-cycle write
    // lands, so a colliding read returns the old word.
    if (r_state_q == R_IDLE) begin
      ld_addr  = axi_req_i.ar.addr;
      ld_size  = axi_req_i.ar.size;
      ld_burst = axi_req_i.ar.burst;
    end else begin
      ld_addr  = r_addr_q;
      ld_size  = r_size_q;
      ld_burst = r_burst_q;
    end
    ld_resp = proto_err(ld_size, ld_burst) ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_MEM_RESPONDER_DECERR_EN
    if (out_of_range(ld_addr)) begin
      ld_resp = RESP_DECERR;
    end
`endif
    ld_data = (ld_resp == RESP_OKAY) ? mem_q[word_idx(ld_addr)] : '0;

    unique case (r_state_q)
      R_IDLE: begin
        if (axi_req_i.ar_valid && ar_ready) begin
          r_id_d    = axi_req_i.ar.id;
          r_len_d   = axi_req_i.ar.len;
          r_size_d  = axi_req_i.ar.size;
          r_burst_d = axi_req_i.ar.burst;
          r_cnt_d   = '0;
          r_last_d  = (axi_req_i.ar.len == '0);
          r_load    = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi_req_i.r_ready && r_valid) begin
          if (r_last_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_last_d = ((r_cnt_q + 8'd1) == r_len_q);
            r_load   = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    if (r_load) begin
      r_data_d = ld_data;
      r_resp_d = ld_resp;
      r_addr_d = next_addr(ld_addr, ld_burst);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_atop_q  <= '0;
      w_cnt_q   <= '0;
      w_bresp_q <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
      r_last_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_atop_q  <= w_atop_d;
      w_cnt_q   <= w_cnt_d;
      w_bresp_q <= w_bresp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
      r_last_q  <= r_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response bundle; the whole bundle reads as zero while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.r_valid  = r_valid;
    if (!rst_i) begin
      axi_resp_o.b.id   = w_id_q;
      axi_resp_o.b.resp = w_bresp_q;
      axi_resp_o.r.id   = r_id_q;
      axi_resp_o.r.data = r_data_q;
      axi_resp_o.r.resp = r_resp_q;
      axi_resp_o.r.last = r_last_q;
    end
  end

  // Request fields this slave has no use for.
  logic unused_req;
  assign unused_req = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                        axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user,
                        axi_req_i.w.last, axi_req_i.w.user,
                        axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                        axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.ar.user};

endmodule
